// File: rtl/zion_riscv_mdu_pkg.sv
// Shared types and helpers for the iterative RISC-V M-extension unit.
package zion_riscv_mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} mdu_state_e;

  typedef enum logic [1:0] {SPC_NONE, SPC_DIV0, SPC_OVF, SPC_ZERO} mdu_spc_e;

  function automatic logic opIsDiv(input mdu_op_e op);
    return op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
  endfunction

  function automatic logic opIsRem(input mdu_op_e op);
    return op inside {MDU_REM, MDU_REMU};
  endfunction

  function automatic logic opSignedA(input mdu_op_e op);
    return op inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
  endfunction

  function automatic logic opSignedB(input mdu_op_e op);
    return op inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM};
  endfunction

  // Ops that bypass the iteration and complete one cycle after accept.
  function automatic mdu_spc_e mduSpecial(input mdu_op_e op, input logic aZero,
                                          input logic bZero, input logic aMinNeg,
                                          input logic bNegOne, input logic earlyEn);
    if (opIsDiv(op) && bZero) return SPC_DIV0;
    if ((op == MDU_DIV || op == MDU_REM) && aMinNeg && bNegOne) return SPC_OVF;
    if (earlyEn && (opIsDiv(op) ? aZero : (aZero || bZero))) return SPC_ZERO;
    return SPC_NONE;
  endfunction

endpackage

// File: rtl/zion_riscv_mdu_iter.sv
// One combinational iteration of the MDU: shift-add multiply step or restoring divide step.
module zion_riscv_mdu_iter
  import zion_riscv_mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              isDiv,
  input  logic [2*XLEN-1:0] accIn,
  input  logic [2*XLEN-1:0] mcandIn,
  input  logic [XLEN-1:0]   mplierIn,
  output logic [2*XLEN-1:0] accOut,
  output logic [2*XLEN-1:0] mcandOut,
  output logic [XLEN-1:0]   mplierOut
);

  logic [XLEN:0] remSh;
  logic [XLEN:0] diff;
  logic          fits;

  // Divide keeps {remainder, dividend/quotient} in acc; divisor sits in mcand's low half.
  always_comb begin
    remSh = accIn[2*XLEN-1:XLEN-1];
    diff  = remSh - {1'b0, mcandIn[XLEN-1:0]};
    fits  = ~diff[XLEN];
    if (isDiv) begin
      accOut    = {(fits ? diff[XLEN-1:0] : remSh[XLEN-1:0]), accIn[XLEN-2:0], fits};
      mcandOut  = mcandIn;
      mplierOut = mplierIn;
    end else begin
      accOut    = mplierIn[0] ? (accIn + mcandIn) : accIn;
      mcandOut  = mcandIn << 1;
      mplierOut = mplierIn >> 1;
    end
  end

endmodule

// File: rtl/zion_riscv_int_mul_div.sv
// Iterative RISC-V M-extension unit, one bit per cycle, valid/ready on both sides.
// Optional zero-operand fast path: define ZION_MDU_EARLY_OUT_EN.
module zion_riscv_int_mul_div
  import zion_riscv_mdu_pkg::*;
#(
  parameter  int RV64  = 0,
  parameter  int TAG_W = 5,
  localparam int XLEN  = (RV64 != 0) ? 64 : 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iVld,
  output logic             iRdy,
  input  mdu_op_e          iOp,
  input  logic             iWord,
  input  logic [XLEN-1:0]  iS1,
  input  logic [XLEN-1:0]  iS2,
  input  logic [TAG_W-1:0] iTag,
  input  logic             iFlush,
  output logic             oVld,
  input  logic             oRdy,
  output logic [XLEN-1:0]  oRslt,
  output logic [TAG_W-1:0] oTag
);

`ifdef ZION_MDU_EARLY_OUT_EN
  localparam logic EarlyEn = 1'b1;
`else
  localparam logic EarlyEn = 1'b0;
`endif

  mdu_state_e        state, stateNxt;
  mdu_op_e           opQ;
  logic              wordQ, negAQ, negBQ;
  logic [6:0]        cnt;
  logic [2*XLEN-1:0] acc, mcand, accNxt, mcandNxt;
  logic [XLEN-1:0]   mplier, mplierNxt;

  logic              wordReq, accept, sgnA, sgnB, negA, negB;
  logic signed [31:0] s1Lo, s2Lo;
  logic [XLEN-1:0]   aExt, bExt, aSext, magA, magB, minNeg, spcRslt;
  mdu_spc_e          spc;

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem, sel, fixRslt;
  logic signed [31:0] selLo;

  assign wordReq = (RV64 != 0) && iWord;
  assign accept  = iVld && iRdy && !iFlush;

  // Request decode: operand extension, magnitudes and special-case result.
  always_comb begin
    sgnA   = opSignedA(iOp);
    sgnB   = opSignedB(iOp);
    s1Lo   = iS1[31:0];
    s2Lo   = iS2[31:0];
    aSext  = wordReq ? XLEN'(s1Lo) : iS1;
    aExt   = wordReq ? (sgnA ? XLEN'(s1Lo) : XLEN'(iS1[31:0])) : iS1;
    bExt   = wordReq ? (sgnB ? XLEN'(s2Lo) : XLEN'(iS2[31:0])) : iS2;
    negA   = sgnA & aExt[XLEN-1];
    negB   = sgnB & bExt[XLEN-1];
    magA   = negA ? -aExt : aExt;
    magB   = negB ? -bExt : bExt;
    minNeg = wordReq ? ({XLEN{1'b1}} << 31) : ({XLEN{1'b1}} << (XLEN-1));
    spc    = mduSpecial(iOp, aExt == '0, bExt == '0, aExt == minNeg, bExt == '1, EarlyEn);
    unique case (spc)
      SPC_DIV0: spcRslt = opIsRem(iOp) ? aSext : '1;
      SPC_OVF:  spcRslt = opIsRem(iOp) ? '0 : aSext;
      default:  spcRslt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    unique case (state)
      IDLE:    if (accept) stateNxt = (spc == SPC_NONE) ? CALC : DONE;
      CALC:    if (cnt == '0) stateNxt = FIX;
      FIX:     stateNxt = DONE;
      DONE:    if (oRdy) stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
    if (iFlush) stateNxt = IDLE;
  end

  always_comb begin
    iRdy = (state == IDLE);
    oVld = (state == DONE);
  end

  zion_riscv_mdu_iter #(.XLEN(XLEN)) uIter (
    .isDiv     (opIsDiv(opQ)),
    .accIn     (acc),
    .mcandIn   (mcand),
    .mplierIn  (mplier),
    .accOut    (accNxt),
    .mcandOut  (mcandNxt),
    .mplierOut (mplierNxt)
  );

  // Sign correction and result selection, used in FIX.
  always_comb begin
    prod = (negAQ ^ negBQ) ? -acc : acc;
    quot = (negAQ ^ negBQ) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = negAQ ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    unique case (opQ)
      MDU_MUL:                         sel = prod[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: sel = prod[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:               sel = quot;
      default:                         sel = rem;
    endcase
    selLo   = sel[31:0];
    fixRslt = wordQ ? XLEN'(selLo) : sel;
  end

  // A word divide left-aligns its 32-bit dividend so 32 shifts leave the quotient in the low bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opQ    <= MDU_MUL;
      wordQ  <= 1'b0;
      negAQ  <= 1'b0;
      negBQ  <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      oRslt  <= '0;
      oTag   <= '0;
    end else if (accept) begin
      opQ   <= iOp;
      wordQ <= wordReq;
      negAQ <= negA;
      negBQ <= negB;
      oTag  <= iTag;
      cnt   <= (wordReq || RV64 == 0) ? 7'd31 : 7'd63;
      if (opIsDiv(iOp)) begin
        acc    <= {{XLEN{1'b0}}, (wordReq ? (magA << (XLEN-32)) : magA)};
        mcand  <= {{XLEN{1'b0}}, magB};
        mplier <= '0;
      end else begin
        acc    <= '0;
        mcand  <= {{XLEN{1'b0}}, magA};
        mplier <= magB;
      end
      if (spc != SPC_NONE) oRslt <= spcRslt;
    end else if (state == CALC) begin
      acc    <= accNxt;
      mcand  <= mcandNxt;
      mplier <= mplierNxt;
      cnt    <= cnt - 7'd1;
    end else if (state == FIX) begin
      oRslt <= fixRslt;
    end
  end

endmodule

// File: tb/tb_zion_riscv_int_mul_div.sv
// Bench for zion_riscv_int_mul_div: RV32 and RV64 instances, directed table, corner sequences, random ops.
module tb_zion_riscv_int_mul_div;
  import zion_riscv_mdu_pkg::*;

  localparam int TAG_W = 5;
`ifdef ZION_MDU_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam int ZLAT = EARLY ? 1 : 34;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vld32 = 1'b0, vld64 = 1'b0;
  mdu_op_e opDrv = MDU_MUL;
  logic wordDrv = 1'b0;
  logic [63:0] s1Drv = '0, s2Drv = '0;
  logic [TAG_W-1:0] tagDrv = '0;
  logic flushDrv = 1'b0, oRdyDrv = 1'b0;

  logic iRdy32, oVld32, iRdy64, oVld64;
  logic [31:0] oRslt32;
  logic [63:0] oRslt64;
  logic [TAG_W-1:0] oTag32, oTag64;

  int nCmp = 0;
  int nBad = 0;

  always #5 clk = ~clk;

  zion_riscv_int_mul_div #(.RV64(0), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .iVld(vld32), .iRdy(iRdy32), .iOp(opDrv), .iWord(wordDrv),
    .iS1(s1Drv[31:0]), .iS2(s2Drv[31:0]), .iTag(tagDrv), .iFlush(flushDrv),
    .oVld(oVld32), .oRdy(oRdyDrv), .oRslt(oRslt32), .oTag(oTag32)
  );

  zion_riscv_int_mul_div #(.RV64(1), .TAG_W(TAG_W)) dut64 (
    .clk(clk), .rst_n(rst_n), .iVld(vld64), .iRdy(iRdy64), .iOp(opDrv), .iWord(wordDrv),
    .iS1(s1Drv), .iS2(s2Drv), .iTag(tagDrv), .iFlush(flushDrv),
    .oVld(oVld64), .oRdy(oRdyDrv), .oRslt(oRslt64), .oTag(oTag64)
  );

  typedef struct {
    bit          use64;
    mdu_op_e     op;
    bit          w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] expR;
    int          expLat;
    int          hold;
  } vec_t;

  function automatic bit rdyOf(input bit u);
    return u ? iRdy64 : iRdy32;
  endfunction
  function automatic bit vldOf(input bit u);
    return u ? oVld64 : oVld32;
  endfunction
  function automatic logic [63:0] rsltOf(input bit u);
    return u ? oRslt64 : {32'b0, oRslt32};
  endfunction
  function automatic logic [TAG_W-1:0] tagOf(input bit u);
    return u ? oTag64 : oTag32;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic on n-bit operand values, result sign-extended for *W.
  function automatic logic [63:0] refModel(input mdu_op_e op, input bit w, input bit is64,
                                           input logic [63:0] a, input logic [63:0] b);
    int n;
    logic signed [129:0] mask, half, ua, ub, sa, sb, p, res;
    n    = (w || !is64) ? 32 : 64;
    mask = (130'sd1 << n) - 130'sd1;
    half = 130'sd1 << (n - 1);
    ua   = {66'b0, a} & mask;
    ub   = {66'b0, b} & mask;
    sa   = (ua ^ half) - half;
    sb   = (ub ^ half) - half;
    case (op)
      MDU_MUL, MDU_MULH: p = sa * sb;
      MDU_MULHSU:        p = sa * ub;
      default:           p = ua * ub;
    endcase
    case (op)
      MDU_MUL:                         res = p & mask;
      MDU_MULH, MDU_MULHSU, MDU_MULHU: res = (p >>> n) & mask;
      MDU_DIV:  res = (ub == 0) ? mask : ((sa / sb) & mask);
      MDU_DIVU: res = (ub == 0) ? mask : ((ua / ub) & mask);
      MDU_REM:  res = (ub == 0) ? ua : ((sa % sb) & mask);
      default:  res = (ub == 0) ? ua : ((ua % ub) & mask);
    endcase
    if (n == 32 && is64) return {{32{res[31]}}, res[31:0]};
    return res[63:0];
  endfunction

  function automatic int refLat(input mdu_op_e op, input bit w, input bit is64,
                                input logic [63:0] a, input logic [63:0] b);
    int n;
    logic [63:0] m, aN, bN, minN;
    bit isDiv;
    n     = (w || !is64) ? 32 : 64;
    m     = (n == 32) ? 64'hFFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    minN  = (n == 32) ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
    aN    = a & m;
    bN    = b & m;
    isDiv = op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
    if (isDiv && bN == 0) return 1;
    if ((op == MDU_DIV || op == MDU_REM) && aN == minN && bN == m) return 1;
    if (EARLY && (isDiv ? (aN == 0) : (aN == 0 || bN == 0))) return 1;
    return n + 2;
  endfunction

  function automatic logic [63:0] pickVal(input bit is64);
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'd1;
      2: return 64'hFFFF_FFFF_FFFF_FFFF;
      3: return is64 ? 64'h8000_0000_0000_0000 : 64'h8000_0000;
      4: return {r[63:32], 32'h8000_0000};
      5: return {r[63:32], 32'hFFFF_FFFF};
      6: return {r[63:32], 32'h0};
      default: return r;
    endcase
  endfunction

  task automatic doOp(input string nm, input bit use64, input mdu_op_e op, input bit w,
                      input logic [63:0] a, input logic [63:0] b, input logic [63:0] expR,
                      input int expLat, input int hold);
    logic [TAG_W-1:0] tg, t0;
    logic [63:0] r0;
    int lat;
    tg = TAG_W'($urandom);
    @(negedge clk);
    opDrv = op; wordDrv = w; s1Drv = a; s2Drv = b; tagDrv = tg;
    if (use64) vld64 = 1'b1; else vld32 = 1'b1;
    @(posedge clk); #1;
    vld32 = 1'b0; vld64 = 1'b0;
    s1Drv = {$urandom, $urandom}; s2Drv = {$urandom, $urandom};
    tagDrv = ~tg; opDrv = mdu_op_e'(3'($urandom)); wordDrv = 1'($urandom);
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk({nm, " iRdyLow"}, 64'(rdyOf(use64)), 64'd0);
      if (vldOf(use64)) break;
    end
    if (!vldOf(use64)) begin
      chk({nm, " timeout"}, 64'(lat), 64'(expLat));
      return;
    end
    chk({nm, " latency"}, 64'(lat), 64'(expLat));
    r0 = rsltOf(use64);
    t0 = tagOf(use64);
    chk({nm, " result"}, r0, expR);
    chk({nm, " tag"}, 64'(t0), 64'(tg));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk({nm, " holdRslt"}, rsltOf(use64), r0);
      chk({nm, " holdTag"}, 64'(tagOf(use64)), 64'(t0));
      chk({nm, " holdVld"}, 64'(vldOf(use64)), 64'd1);
      chk({nm, " holdRdy"}, 64'(rdyOf(use64)), 64'd0);
    end
    oRdyDrv = 1'b1;
    @(posedge clk); #1;
    oRdyDrv = 1'b0;
    chk({nm, " release"}, 64'({vldOf(use64), rdyOf(use64)}), 64'b01);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[16];
    bit seen;
    bit u, w;
    mdu_op_e op;
    logic [63:0] a, b;

    vecs[0]  = '{1'b0, MDU_MUL,    1'b0, 64'h7,         64'hFFFF_FFFD, 64'hFFFF_FFEB, 34, 0};
    vecs[1]  = '{1'b0, MDU_DIVU,   1'b0, 64'd100,       64'd7,         64'd14,        34, 0};
    vecs[2]  = '{1'b0, MDU_REMU,   1'b0, 64'd100,       64'd7,         64'd2,         34, 0};
    vecs[3]  = '{1'b0, MDU_DIV,    1'b0, 64'hFFFF_FF9C, 64'd7,         64'hFFFF_FFF2, 34, 1};
    vecs[4]  = '{1'b0, MDU_REM,    1'b0, 64'hFFFF_FF9C, 64'd7,         64'hFFFF_FFFE, 34, 0};
    vecs[5]  = '{1'b0, MDU_DIV,    1'b0, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 1,  0};
    vecs[6]  = '{1'b0, MDU_REM,    1'b0, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0,         1,  0};
    vecs[7]  = '{1'b0, MDU_DIV,    1'b0, 64'd5,         64'd0,         64'hFFFF_FFFF, 1,  0};
    vecs[8]  = '{1'b0, MDU_REM,    1'b0, 64'd5,         64'd0,         64'd5,         1,  2};
    vecs[9]  = '{1'b0, MDU_MULHU,  1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, 34, 5};
    vecs[10] = '{1'b0, MDU_MULHSU, 1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 34, 5};
    vecs[11] = '{1'b0, MDU_MUL,    1'b0, 64'h0,         64'h1234_5678, 64'h0,         ZLAT, 0};
    vecs[12] = '{1'b1, MDU_DIV,    1'b1, 64'h1_8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 0};
    vecs[13] = '{1'b1, MDU_MUL,    1'b1, 64'h10000,     64'h10000,     64'h0,         34, 0};
    vecs[14] = '{1'b1, MDU_MULHU,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'hFFFF_FFFF_FFFF_FFFE, 66, 0};
    vecs[15] = '{1'b1, MDU_DIVU,   1'b0, 64'h0123_4567_89AB_CDEF, 64'h10,
                 64'h0012_3456_789A_BCDE, 66, 0};

    repeat (3) @(negedge clk);
    chk("rst iRdy32", 64'(iRdy32), 64'd1);
    chk("rst oVld32", 64'(oVld32), 64'd0);
    chk("rst oRslt32", 64'(oRslt32), 64'd0);
    chk("rst oTag32", 64'(oTag32), 64'd0);
    chk("rst iRdy64", 64'(iRdy64), 64'd1);
    chk("rst oVld64", 64'(oVld64), 64'd0);
    chk("rst oRslt64", oRslt64, 64'd0);
    chk("rst oTag64", 64'(oTag64), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++)
      doOp($sformatf("vec%0d", i), vecs[i].use64, vecs[i].op, vecs[i].w, vecs[i].a,
           vecs[i].b, vecs[i].expR, vecs[i].expLat, vecs[i].hold);

    // Flush mid-calculation
    @(negedge clk);
    opDrv = MDU_DIVU; wordDrv = 1'b0; s1Drv = 64'd100; s2Drv = 64'd7; vld32 = 1'b1;
    @(posedge clk); #1; vld32 = 1'b0;
    for (int k = 1; k <= 10; k++) @(negedge clk);
    flushDrv = 1'b1;
    @(negedge clk);
    flushDrv = 1'b0;
    chk("flush iRdy", 64'(iRdy32), 64'd1);
    seen = 1'b0;
    repeat (40) @(negedge clk) if (oVld32) seen = 1'b1;
    chk("flush noVld", 64'(seen), 64'd0);

    // Flush beats a same-cycle request
    @(negedge clk);
    opDrv = MDU_DIV; s1Drv = 64'd5; s2Drv = 64'd0; vld32 = 1'b1; flushDrv = 1'b1;
    @(posedge clk); #1; vld32 = 1'b0; flushDrv = 1'b0;
    chk("flushAcc iRdy", 64'(iRdy32), 64'd1);
    @(negedge clk);
    chk("flushAcc oVld", 64'(oVld32), 64'd0);

    // Flush while DONE with oRdy high consumes the result
    @(negedge clk);
    opDrv = MDU_DIV; s1Drv = 64'd5; s2Drv = 64'd0; vld32 = 1'b1;
    @(posedge clk); #1; vld32 = 1'b0;
    @(negedge clk);
    chk("flushDone oVld", 64'(oVld32), 64'd1);
    flushDrv = 1'b1; oRdyDrv = 1'b1;
    @(posedge clk); #1; flushDrv = 1'b0; oRdyDrv = 1'b0;
    chk("flushDone state", 64'({oVld32, iRdy32}), 64'b01);

    // Asynchronous reset mid-operation
    @(negedge clk);
    opDrv = MDU_MUL; s1Drv = 64'd3; s2Drv = 64'd9; tagDrv = 5'h15; vld32 = 1'b1;
    @(posedge clk); #1; vld32 = 1'b0;
    for (int k = 1; k <= 5; k++) @(negedge clk);
    chk("midop oTag", 64'(oTag32), 64'h15);
    rst_n = 1'b0;
    #1;
    chk("arst iRdy", 64'(iRdy32), 64'd1);
    chk("arst oVld", 64'(oVld32), 64'd0);
    chk("arst oRslt", 64'(oRslt32), 64'd0);
    chk("arst oTag", 64'(oTag32), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) @(negedge clk) if (oVld32) seen = 1'b1;
    chk("arst noVld", 64'(seen), 64'd0);

    for (int i = 0; i < 60; i++) begin
      u  = 1'(i);
      op = mdu_op_e'(3'($urandom_range(0, 7)));
      w  = u && ($urandom_range(0, 2) == 0) && !(op inside {MDU_MULH, MDU_MULHSU, MDU_MULHU});
      a  = pickVal(u);
      b  = pickVal(u);
      doOp($sformatf("rnd%0d", i), u, op, w, a, b, refModel(op, w, u, a, b),
           refLat(op, w, u, a, b), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
